// File: rtl/conv_2.sv
// Sequential 2-D valid-mode correlation engine: one output pixel per clock in raster order,
// each window evaluated combinationally from the live input image.
module conv_2 #(
    parameter int SIZE      = 320,
    parameter int SIZEKer   = 3,
    parameter int WIDTH_BIT = 16,
    parameter logic [SIZEKer*SIZEKer*WIDTH_BIT-1:0] KERNEL = {
        16'h0000, 16'hFFFF, 16'h0000,
        16'hFFFF, 16'h0004, 16'hFFFF,
        16'h0000, 16'hFFFF, 16'h0000
    }
) (
    input  logic                        clock,
    input  logic                        nreset,
    input  logic signed [WIDTH_BIT-1:0] inpMatrixI [SIZE][SIZE],
    output logic                        done,
    output logic signed [WIDTH_BIT-1:0] convIxKernelOut [SIZE-SIZEKer+1][SIZE-SIZEKer+1]
);

    localparam int M     = SIZE - SIZEKer + 1;
    localparam int PW    = 2 * WIDTH_BIT;
    localparam int ACC_W = PW + $clog2(SIZEKer * SIZEKer);
    localparam int CW    = (M > 1) ? $clog2(M) : 1;

    typedef enum logic {
        RUN,
        DONE
    } state_t;

    state_t                    state, state_next;
    logic        [CW-1:0]      row, col, row_next, col_next;
    logic                      last;
    logic signed [WIDTH_BIT-1:0] coef;
    logic signed [PW-1:0]      prod;
    logic signed [ACC_W-1:0]   acc;

    // Window sum for the current (row, col); the accumulator is wide enough that it never wraps.
    // NOTE: combinational blocks use blocking assignments so each loop pass sees the updated acc.
    always_comb begin
        coef = '0;
        prod = '0;
        acc  = '0;
        for (int r = 0; r < SIZEKer; r++) begin
            for (int c = 0; c < SIZEKer; c++) begin
                coef = KERNEL[(r*SIZEKer+c)*WIDTH_BIT +: WIDTH_BIT];
                prod = PW'(coef) * PW'(inpMatrixI[int'(row)+r][int'(col)+c]);
                acc  = acc + ACC_W'(prod);
            end
        end
    end

    always_comb begin
        state_next = state;
        row_next   = row;
        col_next   = col;
        last       = (row == CW'(M - 1)) && (col == CW'(M - 1));
        case (state)
            RUN: begin
                if (col == CW'(M - 1)) begin
                    col_next = '0;
                    row_next = row + CW'(1);
                end else begin
                    col_next = col + CW'(1);
                end
                if (last) state_next = DONE;
            end
            DONE: begin
                state_next = DONE;
            end
            default: state_next = RUN;
        endcase
    end

    assign done = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments; the output map is a register
    // array that reset must clear element by element, since consumers read it as all zeros.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state <= RUN;
            row   <= '0;
            col   <= '0;
            for (int r = 0; r < M; r++) begin
                for (int c = 0; c < M; c++) begin
                    convIxKernelOut[r][c] <= '0;
                end
            end
        end else begin
            state <= state_next;
            row   <= row_next;
            col   <= col_next;
            if (state == RUN) begin
                convIxKernelOut[row][col] <= acc[WIDTH_BIT-1:0];
            end
        end
    end

endmodule

// File: tb/tb_conv_2.sv
// Self-checking bench for conv_2: three small instances (identity, Laplacian, saturating-wrap
// kernels) checked against a plain-arithmetic correlation model, edge by edge.
module tb_conv_2;

    localparam logic [143:0] K_ID   = 144'(1) << 64;
    localparam logic [143:0] K_WRAP = {9{16'h7FFF}};

    logic clock;
    logic nreset;

    int img_id   [5][5];
    int img_lap  [5][5];
    int img_wrap [5][5];
    int save_id  [5][5];

    int ker_id   [3][3] = '{'{0, 0, 0}, '{0, 1, 0}, '{0, 0, 0}};
    int ker_lap  [3][3] = '{'{0, -1, 0}, '{-1, 4, -1}, '{0, -1, 0}};
    int ker_wrap [3][3] = '{'{32767, 32767, 32767}, '{32767, 32767, 32767}, '{32767, 32767, 32767}};

    logic signed [15:0] in_id   [4][4];
    logic signed [15:0] in_lap  [5][5];
    logic signed [15:0] in_wrap [3][3];
    logic signed [15:0] out_id  [2][2];
    logic signed [15:0] out_lap [3][3];
    logic signed [15:0] out_wrap[1][1];
    logic done_id, done_lap, done_wrap;

    int checks = 0;
    int errors = 0;

    always_comb begin
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                in_lap[r][c] = 16'(img_lap[r][c]);
            end
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                in_id[r][c] = 16'(img_id[r][c]);
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                in_wrap[r][c] = 16'(img_wrap[r][c]);
            end
        end
    end

    conv_2 #(.SIZE(4), .SIZEKer(3), .WIDTH_BIT(16), .KERNEL(K_ID)) u_id (
        .clock(clock), .nreset(nreset), .inpMatrixI(in_id),
        .done(done_id), .convIxKernelOut(out_id)
    );

    conv_2 #(.SIZE(5), .SIZEKer(3), .WIDTH_BIT(16)) u_lap (
        .clock(clock), .nreset(nreset), .inpMatrixI(in_lap),
        .done(done_lap), .convIxKernelOut(out_lap)
    );

    conv_2 #(.SIZE(3), .SIZEKer(3), .WIDTH_BIT(16), .KERNEL(K_WRAP)) u_wrap (
        .clock(clock), .nreset(nreset), .inpMatrixI(in_wrap),
        .done(done_wrap), .convIxKernelOut(out_wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Correlation straight from the definition, truncated to the low 16 bits.
    function automatic logic [15:0] model_pix(input int img[5][5], input int ker[3][3],
                                              input int i, input int j);
        longint s = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                s += longint'(ker[r][c]) * longint'(img[i+r][j+c]);
            end
        end
        return s[15:0];
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic rand_img(output int img[5][5]);
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                img[r][c] = int'(shortint'($urandom));
            end
        end
    endtask

    // k = number of edges since reset release: pixels with raster index < k are written.
    task automatic check_id(input int img[5][5], input int k);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                check($sformatf("id[%0d][%0d]@%0d", i, j, k), out_id[i][j],
                      (i*2+j < k) ? model_pix(img, ker_id, i, j) : 16'h0000);
            end
        end
        check($sformatf("id_done@%0d", k), 16'(done_id), 16'(k >= 4));
    endtask

    task automatic check_lap(input int img[5][5], input int k);
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                check($sformatf("lap[%0d][%0d]@%0d", i, j, k), out_lap[i][j],
                      (i*3+j < k) ? model_pix(img, ker_lap, i, j) : 16'h0000);
            end
        end
        check($sformatf("lap_done@%0d", k), 16'(done_lap), 16'(k >= 9));
    endtask

    task automatic check_wrap(input int img[5][5], input int k);
        check($sformatf("wrap[0][0]@%0d", k), out_wrap[0][0],
              (k >= 1) ? model_pix(img, ker_wrap, 0, 0) : 16'h0000);
        check($sformatf("wrap_done@%0d", k), 16'(done_wrap), 16'(k >= 1));
    endtask

    initial begin
        nreset = 1'b0;
        rand_img(img_id);
        rand_img(img_lap);
        rand_img(img_wrap);
        tick();
        tick();
        check_id(img_id, 0);
        check_lap(img_lap, 0);
        check_wrap(img_wrap, 0);

        // Directed: identity ramp, flat Laplacian input, all-max wrap case.
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                img_id[r][c]   = 4 * r + c;
                img_lap[r][c]  = 7;
                img_wrap[r][c] = 32767;
            end
        end
        nreset = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check_id(img_id, k);
            check_lap(img_lap, k);
            check_wrap(img_wrap, k);
            if (k == 1) check("wrap_const", out_wrap[0][0], 16'h0009);
            if (k == 4) begin
                check("id_const00", out_id[0][0], 16'd5);
                check("id_const01", out_id[0][1], 16'd6);
                check("id_const10", out_id[1][0], 16'd9);
                check("id_const11", out_id[1][1], 16'd10);
            end
            if (k == 9) check("lap_const22", out_lap[2][2], 16'h0000);
        end

        // Mid-run reset after edge 2, then a clean full run.
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        tick();
        tick();
        nreset = 1'b0;
        tick();
        check_id(img_id, 0);
        nreset = 1'b1;
        for (int k = 1; k <= 4; k++) tick();
        check_id(img_id, 4);
        check("id_rerun11", out_id[1][1], 16'd10);

        // Hold: changing the input after done must not disturb the map.
        save_id = img_id;
        rand_img(img_id);
        for (int k = 0; k < 10; k++) tick();
        check_id(save_id, 99);

        // Randomized runs, checked pixel by pixel on every edge.
        for (int t = 0; t < 4; t++) begin
            rand_img(img_id);
            rand_img(img_lap);
            rand_img(img_wrap);
            nreset = 1'b0;
            tick();
            nreset = 1'b1;
            for (int k = 1; k <= 10; k++) begin
                tick();
                check_id(img_id, k);
                check_lap(img_lap, k);
                check_wrap(img_wrap, k);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
